shift_pipe_n: RTL and testbench



---
 rtl/shift_pipe_n.sv | 107 ++++++++++
 tb/tb_shift_pipe_n.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe_n.sv
// rtl/shift_pipe_n.sv - pipelined logarithmic barrel shifter with valid/ready handshake
// Stage k shifts or rotates by 2**k when amount bit k is set; one register per stage.
module shift_pipe_n #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH),
  localparam int LATENCY = SHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   b,
  input  logic [2:0]       op,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o,
  output logic             o_zero
);

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  logic                            advance;
  logic                            take;
  logic [LATENCY-1:0]              valid_q;
  logic [LATENCY-1:0]              valid_d;
  logic [LATENCY-1:0][WIDTH-1:0]   data_q;
  logic [LATENCY-1:0][WIDTH-1:0]   data_d;
  logic [LATENCY-1:0][2:0]         op_q;
  logic [LATENCY-1:0][SHW-1:0]     amt_q;
  logic [LATENCY-1:0]              sign_q;
  logic                            zero_q;
  logic                            unused_ctrl;

  function automatic logic [WIDTH-1:0] stage_fn(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       mode,
    input logic             sign,
    input logic             en,
    input int               sh
  );
    logic [WIDTH-1:0] r;
    r = d;
    if (en) begin
      case (mode)
        OP_SLL:  r = d << sh;
        OP_SRL:  r = d >> sh;
        // SRA fills from the sign of the original operand, carried down the pipe
        OP_SRA:  r = (d >> sh) | ({WIDTH{sign}} & ~({WIDTH{1'b1}} >> sh));
        OP_ROL:  r = (d << sh) | (d >> (WIDTH - sh));
        OP_ROR:  r = (d >> sh) | (d << (WIDTH - sh));
        default: r = d;
      endcase
    end
    return r;
  endfunction

  assign advance  = !o_valid || o_ready;
  assign in_ready = advance;
  assign take     = in_valid && advance;

  always_comb begin
    valid_d    = '0;
    data_d     = '0;
    valid_d[0] = take;
    data_d[0]  = take ? stage_fn(a, op, a[WIDTH-1], b[0], 1) : '0;
    for (int k = 1; k < LATENCY; k++) begin
      valid_d[k] = valid_q[k-1];
      data_d[k]  = stage_fn(data_q[k-1], op_q[k-1], sign_q[k-1], amt_q[k-1][k], 1 << k);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      op_q    <= '0;
      amt_q   <= '0;
      sign_q  <= '0;
      zero_q  <= 1'b0;
    end else if (advance) begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      zero_q    <= valid_d[LATENCY-1] && (data_d[LATENCY-1] == '0);
      op_q[0]   <= take ? op : 3'd0;
      amt_q[0]  <= take ? b : '0;
      sign_q[0] <= take && a[WIDTH-1];
      for (int k = 1; k < LATENCY; k++) begin
        op_q[k]   <= op_q[k-1];
        amt_q[k]  <= amt_q[k-1];
        sign_q[k] <= sign_q[k-1];
      end
    end
  end

  // The last stage's control copies and consumed low amount bits are never read again
  assign unused_ctrl = ^{op_q, amt_q, sign_q};

  assign o_valid = valid_q[LATENCY-1];
  assign o       = data_q[LATENCY-1];
  assign o_zero  = zero_q;

endmodule

// File: tb/tb_shift_pipe_n.sv
// tb/tb_shift_pipe_n.sv - self-checking bench for shift_pipe_n
module tb_shift_pipe_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_rst = 1'b1;
  logic       in_valid, in_ready, o_valid, o_ready, o_zero;
  logic [7:0] a, o;
  logic [2:0] b, op;
  int         tests = 0;
  int         fails = 0;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [2:0] b;
    logic [2:0] op;
    logic [7:0] exp;
    logic       zero;
  } vec_t;

  always #5 clk = ~clk;

  shift_pipe_n #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .o_valid(o_valid), .o_ready(o_ready),
    .o(o), .o_zero(o_zero)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: rotation taken from a doubled operand, SRA from a sign-extended operand
  function automatic logic [63:0] model(input int w, input logic [63:0] x, input int sh, input int mode);
    logic [63:0] mask;
    logic [63:0] v;
    logic [63:0] dbl;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    v    = x & mask;
    dbl  = (v << w) | v;
    case (mode)
      0:       return (v << sh) & mask;
      1:       return v >> sh;
      2:       return ((v[w-1] ? (v | ~mask) : v) >> sh) & mask;
      3:       return ((dbl << sh) >> w) & mask;
      4:       return (dbl >> sh) & mask;
      default: return v;
    endcase
  endfunction

  task automatic run_one(input vec_t v);
    logic [2:0] seen;
    @(posedge clk); #1;
    in_valid = 1'b1; a = v.a; b = v.b; op = v.op;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); seen[2] = o_valid;
    @(negedge clk); seen[1] = o_valid;
    @(negedge clk); seen[0] = o_valid;
    check({v.name, " latency"}, 64'(seen), 64'(3'b001));
    check({v.name, " data"}, 64'(o), 64'(v.exp));
    check({v.name, " zero"}, 64'(o_zero), 64'(v.zero));
  endtask

  // Randomised sweeps at other widths, each with its own reset and scoreboard queue
  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int W = (g == 0) ? 2 : (g == 1) ? 16 : 32;
    localparam int S = $clog2(W);
    logic         iv, ir, ov, ordy, oz;
    logic [W-1:0] sa, so;
    logic [S-1:0] sb;
    logic [2:0]   sop;
    logic         done = 1'b0;

    shift_pipe_n #(.WIDTH(W)) dut (
      .clk(clk), .rst(sw_rst), .in_valid(iv), .in_ready(ir),
      .a(sa), .b(sb), .op(sop), .o_valid(ov), .o_ready(ordy),
      .o(so), .o_zero(oz)
    );

    initial begin
      logic [63:0] q[$];
      logic [63:0] e;
      iv = 1'b0; ordy = 1'b1; sa = '0; sb = '0; sop = '0;
      wait (sw_rst == 1'b0);
      for (int cyc = 0; cyc < 300; cyc++) begin
        @(posedge clk); #1;
        if (cyc < 260) begin
          iv   = ($urandom % 4) != 0;
          sa   = W'($urandom);
          sb   = S'($urandom_range(W - 1, 0));
          sop  = 3'($urandom % 8);
          ordy = ($urandom % 4) != 0;
          if (cyc == 0 && W == 16) begin
            iv = 1'b1; sa = W'(16'h8000); sb = S'(15); sop = 3'd2;
          end
        end else begin
          iv = 1'b0; ordy = 1'b1;
        end
        @(negedge clk);
        if (ov && ordy) begin
          if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL sweep%0d spurious: got 0x%0h, expected no result", W, so);
          end else begin
            e = q.pop_front();
            check($sformatf("sweep%0d data", W), 64'(so), e);
            check($sformatf("sweep%0d zero", W), 64'(oz), 64'(e == 64'd0));
          end
        end
        if (iv && ir)
          q.push_back((cyc == 0 && W == 16) ? 64'hFFFF : model(W, 64'(sa), int'(sb), int'(sop)));
      end
      check($sformatf("sweep%0d drained", W), 64'(q.size()), 64'd0);
      done = 1'b1;
    end
  end

  initial begin
    vec_t vecs[10];
    logic stale;
    vecs[0] = '{"sll96", 8'h96, 3'd3, 3'd0, 8'hB0, 1'b0};
    vecs[1] = '{"srl96", 8'h96, 3'd3, 3'd1, 8'h12, 1'b0};
    vecs[2] = '{"sra96", 8'h96, 3'd3, 3'd2, 8'hF2, 1'b0};
    vecs[3] = '{"rol96", 8'h96, 3'd3, 3'd3, 8'hB4, 1'b0};
    vecs[4] = '{"ror96", 8'h96, 3'd3, 3'd4, 8'hD2, 1'b0};
    vecs[5] = '{"sll80", 8'h80, 3'd1, 3'd0, 8'h00, 1'b1};
    vecs[6] = '{"sra80", 8'h80, 3'd7, 3'd2, 8'hFF, 1'b0};
    vecs[7] = '{"ror01", 8'h01, 3'd1, 3'd4, 8'h80, 1'b0};
    vecs[8] = '{"ror_b0", 8'h5A, 3'd0, 3'd4, 8'h5A, 1'b0};
    vecs[9] = '{"pass6", 8'h3C, 3'd5, 3'd6, 8'h3C, 1'b0};

    rst = 1'b1; in_valid = 1'b0; o_ready = 1'b1; a = '0; b = '0; op = '0;
    #12;
    check("reset o_valid", 64'(o_valid), 64'd0);
    check("reset o", 64'(o), 64'd0);
    check("reset o_zero", 64'(o_zero), 64'd0);
    rst = 1'b0;
    #10 sw_rst = 1'b0;
    #1 check("reset in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 10; i++) run_one(vecs[i]);

    // Back-to-back stream: op driven in iteration j emerges in iteration j+3
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      in_valid = (c < 8); a = 8'(c + 1); b = 3'd1; op = 3'd0;
      @(negedge clk);
      if (c < 8) check("stream in_ready", 64'(in_ready), 64'd1);
      if (c >= 3 && c <= 10) begin
        check("stream valid", 64'(o_valid), 64'd1);
        check("stream data", 64'(o), 64'(2 * (c - 2)));
      end else begin
        check("stream bubble", 64'(o_valid), 64'd0);
      end
    end
    in_valid = 1'b0;

    // Backpressure with three ops in flight and a fourth waiting upstream
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      in_valid = (c <= 7);
      a = (c < 3) ? 8'(8'h11 * (c + 1)) : 8'h44;
      b = 3'd0; op = 3'd0;
      o_ready = !(c >= 3 && c <= 6);
      @(negedge clk);
      if (c >= 3 && c <= 6) check("stall in_ready", 64'(in_ready), 64'd0);
      if (c >= 3 && c <= 7) begin
        check("stall valid", 64'(o_valid), 64'd1);
        check("stall hold", 64'(o), 64'h11);
      end
      if (c >= 8) begin
        check("drain valid", 64'(o_valid), 64'd1);
        check("drain data", 64'(o), (c == 8) ? 64'h22 : (c == 9) ? 64'h33 : 64'h44);
      end
      if (c == 7) in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; o_ready = 1'b1;
    repeat (4) @(posedge clk);

    // Reset with two ops in flight, one already at the output
    #1 in_valid = 1'b1; a = 8'h0F; b = 3'd1; op = 3'd0;
    @(posedge clk); #1 a = 8'hF0; op = 3'd1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("pre-reset valid", 64'(o_valid), 64'd1);
    #2 rst = 1'b1;
    #1 check("async reset valid", 64'(o_valid), 64'd0);
    check("async reset zero", 64'(o_zero), 64'd0);
    @(posedge clk); #2 rst = 1'b0;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      stale = stale | o_valid;
    end
    check("no stale result", 64'(stale), 64'd0);
    run_one('{"post-reset rol", 8'h96, 3'd3, 3'd3, 8'hB4, 1'b0});

    for (int i = 0; i < 5000 && !(sw[0].done && sw[1].done && sw[2].done); i++)
      @(posedge clk);
    check("sweeps finished", 64'(sw[0].done && sw[1].done && sw[2].done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
